// File: rtl/unsigned_seq_mult_rs.sv
// Unsigned right-shift shift-and-add multiplier.
// Operands are captured on a load pulse. One multiplier bit is retired on each
// clock edge. The 2N-bit product is final N edges after the load edge, and done
// is raised on that same edge.
module unsigned_seq_mult_rs #(
  parameter int N = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [N-1:0]     a,
  input  logic [N-1:0]     b,
  output logic [2*N-1:0]   product,
  output logic             done
);

  localparam int CW = $clog2(N + 1);

  // Layout of temp:
  //   temp[2N]       carry out of the partial sum
  //   temp[2N-1:N]   partial sum
  //   temp[N-1:0]    multiplier bits still waiting to be retired
  logic [2*N:0]   temp;
  logic [N-1:0]   mcand;
  logic [CW-1:0]  counter;

  logic [N:0]     addend;
  logic [N:0]     sum;
  logic [2*N:0]   shifted;

  // Conditionally add the multiplicand into the upper half, then shift the
  // whole accumulator right by one. The carry bit is kept so that max*max
  // cannot overflow.
  always_comb begin
    addend  = temp[0] ? {1'b0, mcand} : '0;
    sum     = temp[2*N:N] + addend;
    shifted = {1'b0, sum, temp[N-1:1]};
  end

  // Operand capture and iteration. Reset aborts any multiply in flight, and a
  // load restarts the multiply even while one is still in progress.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      temp    <= '0;
      mcand   <= '0;
      counter <= '0;
      done    <= 1'b0;
    end else if (load) begin
      temp    <= {{(N+1){1'b0}}, b};
      mcand   <= a;
      counter <= CW'(N);
      done    <= 1'b0;
    end else if (counter != '0) begin
      temp    <= shifted;
      counter <= counter - CW'(1);
      if (counter == CW'(1)) begin
        done <= 1'b1;
      end
    end
  end

  assign product = temp[2*N-1:0];

endmodule

// File: tb/tb_unsigned_seq_mult_rs.sv
// Scoreboard testbench for unsigned_seq_mult_rs.
// The stimulus side pushes {a*b, due cycle} for every load it issues. The
// monitor pops an entry and checks it each time done rises.
module tb_unsigned_seq_mult_rs;

  localparam int N = 6;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           load = 1'b0;
  logic [N-1:0]   a = '0;
  logic [N-1:0]   b = '0;
  logic [2*N-1:0] product;
  logic           done;

  typedef struct {
    int expProduct;
    int dueCycle;
  } exp_t;

  exp_t scoreboard[$];

  int testsRun    = 0;
  int testsFailed = 0;
  int cycleCount  = 0;
  bit prevDone    = 1'b0;

  unsigned_seq_mult_rs #(.N(N)) dut (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .a       (a),
    .b       (b),
    .product (product),
    .done    (done)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Count rising edges so that latency can be checked against the load edge.
  always @(posedge clk) cycleCount <= cycleCount + 1;

  // Overall time limit, so the run can never hang.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    testsRun++;
    if (actual != expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cycleCount);
    end
  endtask

  // Drive a load for exactly one edge and record the expected result.
  // This task returns just after the load edge.
  task automatic applyStimulus(input int opA, input int opB);
    exp_t e;
    @(negedge clk); #1;
    a    = N'(opA);
    b    = N'(opB);
    load = 1'b1;
    scoreboard.delete();
    e.expProduct = opA * opB;
    e.dueCycle   = cycleCount + 1 + N;
    scoreboard.push_back(e);
    @(negedge clk); #1;
    load = 1'b0;
  endtask

  task automatic idleCycles(input int n, input bit scramble);
    repeat (n) begin
      @(negedge clk); #1;
      if (scramble) begin
        a = N'($urandom);
        b = N'($urandom);
      end
    end
  endtask

  // Drop reset asynchronously and check that the outputs clear before any clock edge.
  task automatic abortWithReset(input string name);
    rst = 1'b0;
    scoreboard.delete();
    #1;
    checkOutput({name, "_product"}, int'(product), 0);
    checkOutput({name, "_done"}, int'(done), 0);
    @(negedge clk); #1;
    rst = 1'b1;
  endtask

  task automatic runOp(input int opA, input int opB);
    applyStimulus(opA, opB);
    idleCycles(N, 1'b0);
    checkOutput("done_after_N", int'(done), 1);
  endtask

  // Monitor: on each rising edge of done, check the product and the latency
  // against the oldest expectation. An expectation that passes its due cycle
  // without done is reported as a timeout.
  always @(negedge clk) begin
    exp_t e;
    if (done && !prevDone) begin
      if (scoreboard.size() == 0) begin
        testsRun++;
        testsFailed++;
        $display("[TB] FAIL unexpected_done: got done=1, expected no pending result (cycle %0d)", cycleCount);
      end else begin
        e = scoreboard.pop_front();
        checkOutput("product", int'(product), e.expProduct);
        checkOutput("latency", cycleCount, e.dueCycle);
      end
    end else if (scoreboard.size() != 0 && cycleCount > scoreboard[0].dueCycle) begin
      e = scoreboard.pop_front();
      testsRun++;
      testsFailed++;
      $display("[TB] FAIL timeout: got done=0, expected done=1 by cycle %0d", e.dueCycle);
    end
    prevDone = done;
  end

  initial begin
    int mode;
    int opA;
    int opB;

    // Reset held low with load and operands active.
    rst  = 1'b0;
    load = 1'b1;
    a    = 6'd42;
    b    = 6'd51;
    repeat (2) begin
      @(negedge clk); #1;
      checkOutput("reset_product", int'(product), 0);
      checkOutput("reset_done", int'(done), 0);
    end
    load = 1'b0;
    rst  = 1'b1;
    idleCycles(2, 1'b1);
    checkOutput("post_reset_product", int'(product), 0);
    checkOutput("post_reset_done", int'(done), 0);

    // Max operands: done must stay low until edge N, then the result holds.
    applyStimulus(63, 63);
    checkOutput("done_low_0", int'(done), 0);
    for (int k = 1; k < N; k++) begin
      @(negedge clk); #1;
      checkOutput("done_low_early", int'(done), 0);
    end
    idleCycles(4, 1'b0);
    checkOutput("max_hold_product", int'(product), 3969);
    checkOutput("max_hold_done", int'(done), 1);

    // Reset after completion clears the held result at once.
    abortWithReset("reset_after_done");

    // Zero, identity and mixed values.
    runOp(0, 45);
    runOp(1, 63);
    runOp(37, 1);
    runOp(13, 11);
    checkOutput("mixed_product", int'(product), 143);

    // Restart: the second load discards the first multiply.
    applyStimulus(5, 7);
    idleCycles(2, 1'b0);
    applyStimulus(9, 9);
    idleCycles(N + 1, 1'b0);
    checkOutput("restart_product", int'(product), 81);

    // Abort part-way through a multiply.
    applyStimulus(21, 17);
    idleCycles(3, 1'b0);
    abortWithReset("abort_mid");
    idleCycles(2, 1'b0);
    checkOutput("abort_stays_done", int'(done), 0);

    // Operands changing after load have no effect.
    applyStimulus(20, 30);
    idleCycles(N + 2, 1'b1);
    checkOutput("opchange_product", int'(product), 600);

    // Randomized mix of completions, restarts and resets.
    for (int i = 0; i < 40; i++) begin
      opA  = int'($urandom_range(0, 63));
      opB  = int'($urandom_range(0, 63));
      mode = int'($urandom_range(0, 9));
      applyStimulus(opA, opB);
      if (mode < 6) begin
        idleCycles(N + int'($urandom_range(0, 3)), 1'b1);
      end else if (mode < 9) begin
        idleCycles(int'($urandom_range(0, N - 2)), 1'b1);
      end else begin
        idleCycles(int'($urandom_range(1, N - 1)), 1'b1);
        abortWithReset("random_abort");
      end
    end

    idleCycles(N + 3, 1'b0);
    if (scoreboard.size() != 0) begin
      testsRun++;
      testsFailed++;
      $display("[TB] FAIL pending: got %0d outstanding results, expected 0", scoreboard.size());
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/unsigned_seq_mult_rs.md
Name: unsigned_seq_mult_rs

Overview:
Unsigned sequential multiplier using the right-shift shift-and-add algorithm. Operands are captured on a load pulse. One multiplier bit is retired per clock. The 2N-bit product is available N cycles after the load edge. It serves as a small-area multiply unit for datapaths that can tolerate multi-cycle latency.

Parameters:
- N, 6, operand width in bits; product width is 2N; counter width is clog2(N+1).

Ports:
- clk  input  1  single system clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-low reset; clears all state immediately when low.
- load  input  1  synchronous start; captures a and b on the rising clk edge when high.
- a  input  N  unsigned multiplicand.
- b  input  N  unsigned multiplier.
- product  output  2N  working product register; equals a*b once done is high.
- done  output  1  high when the multiply has completed and product is final.

Behaviour:
- Internal state:
  - temp: (2N+1)-bit accumulator/shift register. The upper part is the partial sum plus carry; the lower N bits initially hold the multiplier.
  - mcand: N-bit multiplicand register.
  - counter: count of remaining iterations.
  - product is driven as temp[2N-1:0].
- Reset (rst=0, asynchronous):
  - temp, mcand and counter are cleared to 0.
  - product=0, done=0.
  - Reset dominates load.
  - Reset mid-operation aborts the operation; no partial result is retained.
- Load edge (rst=1, load=1):
  - temp <= {0, a-free upper part = 0, b}; i.e. upper N+1 bits = 0 and lower N bits = b.
  - mcand <= a.
  - counter <= N.
  - done <= 0.
- Load while busy restarts with the new operands; the previous operation is discarded.
- Iterate edge (rst=1, load=0, counter != 0):
  - If temp[0]=1, add mcand to temp[2N-1:N] with carry into temp[2N].
  - Logically shift the whole (2N+1)-bit temp right by 1.
  - counter <= counter-1.
  - When counter transitions 1->0, done <= 1 on that same edge.
- Idle edge (load=0, counter=0): state holds. product and done are stable indefinitely.
- Latency:
  - Exactly N rising edges after the load edge; product = a*b after edge N.
  - Intermediate product values during iteration are partial sums, not valid results.
- Width rules:
  - Unsigned only.
  - The carry bit is required so that max*max (63*63=3969) does not overflow.
  - product never exceeds (2^N-1)^2.
- a and b may change after the load edge without affecting the result.
- Behaviour with rst held low ignores load and clock.
- Power-up without reset is undefined; a bench must reset first.

Test Plan:
1. Reset: rst=0 for 2 cycles with arbitrary inputs -> product=0, done=0, counter=0. Reassert rst=1 -> outputs remain 0 until load.
2. Max operands: load a=6'b111111, b=6'b111111 for one edge, then load=0 -> done rises after exactly 6 further edges; product=12'b111110000001 (3969). Holds thereafter.
3. Zero and identity: a=0, b=45 -> product=0. a=1, b=63 -> 63. a=37, b=1 -> 37. All after 6 cycles with done=1.
4. Mixed values: a=13, b=11 -> 143 (12'h08F). Check counter decrements 6..0 and that done is low before cycle 6.
5. Restart and abort:
   - Load a=5, b=7, then reload a=9, b=9 at cycle 3 -> product=81, done 6 cycles after the second load.
   - Drop rst low at cycle 4 of another multiply -> product=0 and done=0 immediately, asynchronously before the next clk edge.
6. Operand change: change a and b every cycle after load a=20, b=30 -> product=600, unaffected by the later input changes.
